// File: rtl/regwrite_if.sv
// Bundle of the ALU write, load-return, register-file write and forwarding
// signals that surround the register-file write buffer.
interface regwrite_if;
    logic        alu_we;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_waddr;
    logic [31:0] ld_wdata;
    logic        rf_rw;
    logic [4:0]  rf_addr3;
    logic [31:0] rf_wdata;
    logic [4:0]  q_addr1;
    logic [4:0]  q_addr2;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd1_data;
    logic [31:0] fwd2_data;
    logic [2:0]  count;

    modport master (
        output alu_we, alu_waddr, alu_wdata,
        output ld_valid, ld_waddr, ld_wdata,
        output q_addr1, q_addr2,
        input  ld_ready, rf_rw, rf_addr3, rf_wdata,
        input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
    );

    modport slave (
        input  alu_we, alu_waddr, alu_wdata,
        input  ld_valid, ld_waddr, ld_wdata,
        input  q_addr1, q_addr2,
        output ld_ready, rf_rw, rf_addr3, rf_wdata,
        output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
    );
endinterface

// File: rtl/regwrite_buffer.sv
// Arbitrates the single register-file write port between the ALU and a small
// FIFO of pending load results, with kill-on-overwrite and operand forwarding.
module regwrite_buffer #(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    regwrite_if.slave bus
);
    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [2:0]       count_q, count_d;
    logic [4:0]       addr_q [DEPTH];
    logic [4:0]       addr_d [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic             live_q [DEPTH];
    logic             live_d [DEPTH];

    logic             alu_eff_s;
    logic             ld_ready_s;
    logic             push_s;
    logic             pop_s;
    logic             head_live_s;
    logic             push_live_s;
    logic [PTR_W-1:0] rel_s  [DEPTH];
    logic             occ_s  [DEPTH];
    logic [PTR_W-1:0] fidx_s [DEPTH];
    logic             buf1_hit_s, buf2_hit_s;
    logic [31:0]      buf1_data_s, buf2_data_s;

    // Per-cycle control decode; everything is gated by rst so reset silences outputs at once.
    always_comb begin
        alu_eff_s   = !rst && bus.alu_we && (bus.alu_waddr != 5'd0);
        ld_ready_s  = !rst && (count_q < DEPTH_C);
        push_s      = bus.ld_valid && ld_ready_s;
        pop_s       = !rst && (count_q != 3'd0) && !alu_eff_s;
        head_live_s = (count_q != 3'd0) && live_q[head_q];
        // A load aimed at r0 or at the register the ALU writes this cycle is stale on arrival.
        push_live_s = (bus.ld_waddr != 5'd0) &&
                      !(bus.alu_we && (bus.alu_waddr == bus.ld_waddr));
    end

    // Slot occupancy and age-ordered slot indices, both relative to the head.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rel_s[i]  = PTR_W'(i) - head_q;
            occ_s[i]  = (3'(rel_s[i]) < count_q);
            fidx_s[i] = head_q + PTR_W'(i);
        end
    end

    // Register-file write port: the ALU always wins, otherwise a live head drains.
    always_comb begin
        bus.ld_ready = ld_ready_s;
        bus.count    = count_q;
        if (alu_eff_s) begin
            bus.rf_rw    = 1'b1;
            bus.rf_addr3 = bus.alu_waddr;
            bus.rf_wdata = bus.alu_wdata;
        end else if (!rst && head_live_s) begin
            bus.rf_rw    = 1'b1;
            bus.rf_addr3 = addr_q[head_q];
            bus.rf_wdata = data_q[head_q];
        end else begin
            bus.rf_rw    = 1'b0;
            bus.rf_addr3 = 5'd0;
            bus.rf_wdata = 32'd0;
        end
    end

    // Youngest live buffered match per read port; later (younger) slots override earlier ones.
    always_comb begin
        buf1_hit_s  = 1'b0;
        buf1_data_s = 32'd0;
        buf2_hit_s  = 1'b0;
        buf2_data_s = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((3'(i) < count_q) && live_q[fidx_s[i]] && (addr_q[fidx_s[i]] == bus.q_addr1)) begin
                buf1_hit_s  = 1'b1;
                buf1_data_s = data_q[fidx_s[i]];
            end else begin
                buf1_hit_s  = buf1_hit_s;
                buf1_data_s = buf1_data_s;
            end
            if ((3'(i) < count_q) && live_q[fidx_s[i]] && (addr_q[fidx_s[i]] == bus.q_addr2)) begin
                buf2_hit_s  = 1'b1;
                buf2_data_s = data_q[fidx_s[i]];
            end else begin
                buf2_hit_s  = buf2_hit_s;
                buf2_data_s = buf2_data_s;
            end
        end
    end

    // Forwarding outputs: r0 never hits, the in-flight ALU value beats any buffered one.
    always_comb begin
        if (rst || (bus.q_addr1 == 5'd0)) begin
            bus.fwd1_hit  = 1'b0;
            bus.fwd1_data = 32'd0;
        end else if (alu_eff_s && (bus.alu_waddr == bus.q_addr1)) begin
            bus.fwd1_hit  = 1'b1;
            bus.fwd1_data = bus.alu_wdata;
        end else if (buf1_hit_s) begin
            bus.fwd1_hit  = 1'b1;
            bus.fwd1_data = buf1_data_s;
        end else begin
            bus.fwd1_hit  = 1'b0;
            bus.fwd1_data = 32'd0;
        end
        if (rst || (bus.q_addr2 == 5'd0)) begin
            bus.fwd2_hit  = 1'b0;
            bus.fwd2_data = 32'd0;
        end else if (alu_eff_s && (bus.alu_waddr == bus.q_addr2)) begin
            bus.fwd2_hit  = 1'b1;
            bus.fwd2_data = bus.alu_wdata;
        end else if (buf2_hit_s) begin
            bus.fwd2_hit  = 1'b1;
            bus.fwd2_data = buf2_data_s;
        end else begin
            bus.fwd2_hit  = 1'b0;
            bus.fwd2_data = 32'd0;
        end
    end

    // Next-state for the FIFO: kill, pop and push touch distinct slots when they coincide.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        live_d = live_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_eff_s && occ_s[i] && (addr_q[i] == bus.alu_waddr)) begin
                live_d[i] = 1'b0;
            end else begin
                live_d[i] = live_q[i];
            end
        end
        if (pop_s) begin
            live_d[head_q] = 1'b0;
            head_d         = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end
        if (push_s) begin
            addr_d[tail_q] = bus.ld_waddr;
            data_d[tail_q] = bus.ld_wdata;
            live_d[tail_q] = push_live_s;
            tail_d         = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers with asynchronous clear of every slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 5'd0;
                data_q[i] <= 32'd0;
                live_q[i] <= 1'b0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            live_q  <= live_d;
        end
    end
endmodule

// File: doc/regwrite_buffer.md
REGWRITE_BUFFER -- requirements
Module: regwrite_buffer

Interface
REQ-001 Parameter: DEPTH, 2, number of pending-write entries for the load source (legal values 2 or 4).
REQ-002 Port: clk  in  1  clock; all state updates on the rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: alu_we  in  1  single-cycle ALU write request this cycle.
REQ-005 Port: alu_waddr  in  5  ALU destination register.
REQ-006 Port: alu_wdata  in  32  ALU result.
REQ-007 Port: ld_valid  in  1  load/multi-cycle result valid.
REQ-008 Port: ld_ready  out  1  buffer can accept a load result.
REQ-009 Port: ld_waddr  in  5  load destination register.
REQ-010 Port: ld_wdata  in  32  load result.
REQ-011 Port: rf_rw  out  1  register-file write enable.
REQ-012 Port: rf_addr3  out  5  register-file write address.
REQ-013 Port: rf_wdata  out  32  register-file write data.
REQ-014 Port: q_addr1, q_addr2  in  5 each  read addresses presented to the register file.
REQ-015 Port: fwd1_hit, fwd2_hit  out  1 each  pending write matches q_addr1/q_addr2.
REQ-016 Port: fwd1_data, fwd2_data  out  32 each  forwarded value (0 when no hit).
REQ-017 Port: count  out  3  valid-or-killed entries occupying the buffer.

Function
REQ-018 Buffer is a circular FIFO of DEPTH entries {addr, data, live}; head/tail pointers wrap modulo DEPTH.
REQ-019 ld_ready = !rst && (count < DEPTH); combinational; simultaneous pop does not raise ld_ready in the same cycle.
REQ-020 Load accepted at an edge where ld_valid && ld_ready; entry pushed at tail with live=1, except live=0 when ld_waddr==0 or (alu_we && alu_waddr==ld_waddr) in that cycle (ALU is younger; load is dropped).
REQ-021 ALU write is effective when alu_we && alu_waddr!=0; ALU has absolute priority on the register-file port.
REQ-022 Port drive (combinational): effective ALU write -> rf_rw=1, rf_addr3=alu_waddr, rf_wdata=alu_wdata; else head entry present and live -> rf_rw=1 with head addr/data; else rf_rw=0, rf_addr3=0, rf_wdata=0.
REQ-023 Pop: head removed at the edge when buffer non-empty and no effective ALU write (live head written; killed head discarded with rf_rw=0).
REQ-024 Kill: at an edge with an effective ALU write, every occupied entry whose addr==alu_waddr gets live=0 (older load never overwrites newer ALU value).
REQ-025 Push and pop at the same edge: count unchanged, both pointers advance.
REQ-026 Forwarding (combinational, per port n): q_addrn==0 -> hit=0; else effective ALU write with matching addr -> that data; else youngest live matching entry -> its data; else hit=0, data=0.
REQ-027 count never exceeds DEPTH; no write ever issued to register 0.
REQ-028 Latency: load result accepted at edge N is written to the register file no earlier than edge N+1, exactly at N+1 if buffer was empty and no ALU write occurs in cycle N+1.

Reset
REQ-029 While rst=1: pointers 0, count=0, all live bits 0, ld_ready=0, rf_rw=0, rf_addr3=0, rf_wdata=0, fwd*_hit=0, fwd*_data=0.
REQ-030 rst asserted mid-operation discards all pending entries immediately; no partial write reaches rf_rw after reset asserts.
REQ-031 First load acceptance possible at the first rising edge after rst deasserts.

Verification
REQ-032 Empty buffer, load {r5, 0xDEAD0001}, no ALU -> next cycle rf_rw=1, rf_addr3=5, rf_wdata=0xDEAD0001, count returns 0.
REQ-033 DEPTH=2, ALU writes r1..r3 on three consecutive cycles while loads r8, r9 arrive -> ld_ready=0 after two pushes, loads drain in order r8 then r9 once ALU idles.
REQ-034 Load r4=0x11 buffered, then ALU r4=0x22 -> entry killed, register file sees only 0x22; fwd on q_addr1=4 returns 0x22 during ALU cycle, no hit after.
REQ-035 Same cycle ALU r7=0xAA and load r7=0xBB -> load accepted but dropped, only 0xAA written; load to r0 -> accepted, never written.
REQ-036 Two live entries, rst pulsed asynchronously between edges -> outputs zero immediately, count=0, no subsequent write of either entry.
